// File: rtl/cursor_motion.sv
// Per-frame keyboard-driven cursor position generator with press-and-hold acceleration,
// on-screen clamping of the diamond, and a valid/ready click event on each spacebar press.
module cursor_motion #(
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 639,
   parameter int Y_MIN        = 0,
   parameter int Y_MAX        = 479,
   parameter int SIZE         = 4,
   parameter int X_START      = 320,
   parameter int Y_START      = 240,
   parameter int ACCEL_FRAMES = 8,
   parameter int MAX_STEP     = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic [9:0] CursorX,
   output logic [9:0] CursorY,
   output logic [9:0] CursorSize,
   output logic       click_valid,
   output logic [9:0] click_x,
   output logic [9:0] click_y,
   input  logic       click_ready
);

   typedef enum logic {IDLE, MOVING} state_t;
   typedef enum logic [2:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;

   localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
   localparam logic signed [10:0] X_LO = 11'(X_MIN + SIZE);
   localparam logic signed [10:0] X_HI = 11'(X_MAX - SIZE);
   localparam logic signed [10:0] Y_LO = 11'(Y_MIN + SIZE);
   localparam logic signed [10:0] Y_HI = 11'(Y_MAX - SIZE);

   state_t             state_q, state_d;
   dir_t               dir_last_q, dir_last_d;
   dir_t               dir;
   logic [9:0]         step_q, step_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [9:0]         x_q, x_d, y_q, y_d;
   logic               frame_clk_q, space_q;
   logic               click_valid_q, click_valid_d;
   logic [9:0]         click_x_q, click_x_d, click_y_q, click_y_d;

   logic               frame_tick, space_now, press, do_move;
   logic [9:0]         move_amt, step_dbl;
   logic [CNT_W-1:0]   cnt_inc;
   logic signed [10:0] amt_s, dx, dy, x_sum, y_sum;

   function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                        input logic signed [10:0] lo,
                                        input logic signed [10:0] hi);
      if (v < lo)      return lo[9:0];
      else if (v > hi) return hi[9:0];
      else             return v[9:0];
   endfunction

   always_comb begin
      unique case (keycode)
         8'h04:   dir = DIR_LEFT;
         8'h07:   dir = DIR_RIGHT;
         8'h1A:   dir = DIR_UP;
         8'h16:   dir = DIR_DOWN;
         default: dir = DIR_NONE;
      endcase
   end

   assign frame_tick = frame_clk & ~frame_clk_q;
   assign space_now  = (keycode == 8'h2C);
   assign press      = space_now & ~space_q;
   assign cnt_inc    = cnt_q + CNT_W'(1);
   assign step_dbl   = {step_q[8:0], 1'b0};

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      dir_last_d = dir_last_q;
      step_d     = step_q;
      cnt_d      = cnt_q;
      do_move    = 1'b0;
      move_amt   = 10'd0;
      if (frame_tick) begin
         if (dir == DIR_NONE) begin
            state_d = IDLE;
            step_d  = 10'd1;
            cnt_d   = '0;
         end else if (state_q == IDLE || dir != dir_last_q) begin
            state_d    = MOVING;
            dir_last_d = dir;
            step_d     = 10'd1;
            cnt_d      = CNT_W'(1);
            do_move    = 1'b1;
            move_amt   = 10'd1;
         end else begin
            do_move  = 1'b1;
            move_amt = step_q;
            if (cnt_inc == CNT_W'(ACCEL_FRAMES)) begin
               step_d = (step_dbl > 10'(MAX_STEP)) ? 10'(MAX_STEP) : step_dbl;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      end
   end

   // Signed 11-bit sums let a step past either edge be seen and clamped instead of wrapping.
   always_comb begin
      amt_s = $signed({1'b0, move_amt});
      dx    = '0;
      dy    = '0;
      unique case (dir)
         DIR_LEFT:  dx = -amt_s;
         DIR_RIGHT: dx = amt_s;
         DIR_UP:    dy = -amt_s;
         DIR_DOWN:  dy = amt_s;
         default: ;
      endcase
      x_sum = $signed({1'b0, x_q}) + dx;
      y_sum = $signed({1'b0, y_q}) + dy;
      x_d   = do_move ? clamp(x_sum, X_LO, X_HI) : x_q;
      y_d   = do_move ? clamp(y_sum, Y_LO, Y_HI) : y_q;
   end

   // Capture reads the registered position, so a same-cycle frame update is not seen.
   always_comb begin
      click_valid_d = click_valid_q;
      click_x_d     = click_x_q;
      click_y_d     = click_y_q;
      if (press && !click_valid_q) begin
         click_valid_d = 1'b1;
         click_x_d     = x_q;
         click_y_d     = y_q;
      end else if (click_valid_q && click_ready) begin
         click_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= IDLE;
         dir_last_q    <= DIR_NONE;
         step_q        <= 10'd1;
         cnt_q         <= '0;
         x_q           <= 10'(X_START);
         y_q           <= 10'(Y_START);
         // NOTE: reset high so a frame_clk already high at release does not look like an edge.
         frame_clk_q   <= 1'b1;
         space_q       <= 1'b0;
         click_valid_q <= 1'b0;
         click_x_q     <= '0;
         click_y_q     <= '0;
      end else begin
         state_q       <= state_d;
         dir_last_q    <= dir_last_d;
         step_q        <= step_d;
         cnt_q         <= cnt_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_clk_q   <= frame_clk;
         space_q       <= space_now;
         click_valid_q <= click_valid_d;
         click_x_q     <= click_x_d;
         click_y_q     <= click_y_d;
      end
   end

   assign CursorX     = x_q;
   assign CursorY     = y_q;
   assign CursorSize  = 10'(SIZE);
   assign click_valid = click_valid_q;
   assign click_x     = click_x_q;
   assign click_y     = click_y_q;

endmodule

// File: tb/tb_cursor_motion.sv
// Scoreboard bench for cursor_motion: driver runs a frame-level reference model and queues
// expected positions/clicks; an independent monitor checks DUT outputs as they appear.
module tb_cursor_motion;

   localparam int XS = 320, YS = 240, ACC = 8, MAXS = 8;
   localparam int XLO = 4, XHI = 635, YLO = 4, YHI = 475;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       click_ready = 1'b0;
   logic [9:0] CursorX, CursorY, CursorSize, click_x, click_y;
   logic       click_valid;

   cursor_motion dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .CursorX(CursorX), .CursorY(CursorY), .CursorSize(CursorSize),
      .click_valid(click_valid), .click_x(click_x), .click_y(click_y),
      .click_ready(click_ready)
   );

   always #5 Clk = ~Clk;

   typedef struct {int x; int y;} pt_t;
   pt_t pos_q[$];
   pt_t clk_q[$];
   bit  vq[$];

   int tests = 0;
   int fails = 0;
   bit mon_en = 0;

   // Reference model state: position, current direction and length of the current run.
   int m_x, m_y, m_dir, m_run;
   bit m_fprev, m_sprev, m_pend;

   task automatic check(input string name, input integer act, input integer exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [7:0] kc);
      case (kc)
         8'h04: return 1;
         8'h07: return 2;
         8'h1A: return 3;
         8'h16: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic int lim(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   // One clock: drive inputs at the falling edge and predict the effect of the next rising edge.
   task automatic cycle(input logic [7:0] kc, input logic f, input logic rdy, input logic rst);
      bit tick, sp, press;
      int d, sh, st;
      @(negedge Clk);
      keycode = kc; frame_clk = f; click_ready = rdy; Reset = rst;
      if (rst) begin
         mon_en = 1;
         m_x = XS; m_y = YS; m_dir = 0; m_run = 0;
         m_fprev = 1; m_sprev = 0; m_pend = 0;
         pos_q.delete(); clk_q.delete();
         vq.push_back(1'b0);
         return;
      end
      tick = f && !m_fprev;
      m_fprev = f;
      sp = (kc == 8'h2C);
      press = sp && !m_sprev;
      m_sprev = sp;
      if (press && !m_pend) begin
         clk_q.push_back('{m_x, m_y});
         m_pend = 1;
      end else if (m_pend && rdy) begin
         m_pend = 0;
      end
      if (tick) begin
         d = decode(kc);
         if (d == 0) begin
            m_run = 0;
         end else begin
            m_run = (d != m_dir || m_run == 0) ? 1 : m_run + 1;
            m_dir = d;
            sh = (m_run - 1) / ACC;
            st = (sh >= 10) ? MAXS : (((1 << sh) > MAXS) ? MAXS : (1 << sh));
            case (d)
               1: m_x = lim(m_x - st, XLO, XHI);
               2: m_x = lim(m_x + st, XLO, XHI);
               3: m_y = lim(m_y - st, YLO, YHI);
               default: m_y = lim(m_y + st, YLO, YHI);
            endcase
         end
         pos_q.push_back('{m_x, m_y});
      end
      vq.push_back(m_pend);
   endtask

   task automatic frame(input logic [7:0] kc, input int n);
      repeat (n) begin
         cycle(kc, 1'b1, 1'b0, 1'b0);
         repeat (3) cycle(kc, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Monitor: independent of the driver, reacts to what the DUT presents after each edge.
   bit  mon_pf = 1'b1;
   bit  mon_pv = 1'b0;
   int  mon_lx = XS, mon_ly = YS;
   pt_t mon_p;
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (mon_en) begin
            if (Reset) begin
               mon_pf = 1'b1;
               mon_lx = XS;
               mon_ly = YS;
            end else begin
               if (frame_clk && !mon_pf) begin
                  if (pos_q.size() == 0) begin
                     check("pos_update_unexpected", 1, 0);
                  end else begin
                     mon_p  = pos_q.pop_front();
                     mon_lx = mon_p.x;
                     mon_ly = mon_p.y;
                  end
               end
               mon_pf = frame_clk;
               if (mon_pv && click_ready && clk_q.size() > 0) void'(clk_q.pop_front());
            end
            check("cursor_x", CursorX, mon_lx);
            check("cursor_y", CursorY, mon_ly);
            if (click_valid) begin
               if (clk_q.size() == 0) begin
                  check("click_spurious", click_valid, 0);
               end else begin
                  check("click_x", click_x, clk_q[0].x);
                  check("click_y", click_y, clk_q[0].y);
               end
            end
            if (vq.size() > 0) check("click_valid", click_valid, vq.pop_front());
            mon_pv = click_valid;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

   initial begin
      logic [7:0] kc;
      int r, len;

      repeat (2) cycle(8'h00, 1'b0, 1'b0, 1'b1);
      frame(8'h00, 3);
      check("size", CursorSize, 4);
      check("idle_x", CursorX, 320);
      check("idle_y", CursorY, 240);
      check("idle_click", click_valid, 0);

      frame(8'h07, 8);  check("right_f8", CursorX, 328);
      frame(8'h07, 8);  check("right_f16", CursorX, 344);
      frame(8'h07, 8);  check("right_f24", CursorX, 376);
      frame(8'h07, 8);  check("right_f32_max", CursorX, 440);

      cycle(8'h00, 1'b0, 1'b0, 1'b1);
      frame(8'h04, 200); check("left_sat", CursorX, 4);
      frame(8'h07, 1);   check("dir_change", CursorX, 5);

      frame(8'h16, 150); check("down_sat", CursorY, 475);
      frame(8'h00, 1);
      frame(8'h16, 1);   check("down_sat_again", CursorY, 475);
      frame(8'h1A, 11);  check("up_accel", CursorY, 461);
      frame(8'h00, 1);
      frame(8'h1A, 1);   check("up_restart", CursorY, 460);

      repeat (10) cycle(8'h2C, 1'b0, 1'b0, 1'b0);
      check("click_held_valid", click_valid, 1);
      check("click_cap_x", click_x, 5);
      check("click_cap_y", click_y, 460);
      repeat (3) cycle(8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(8'h2C, 1'b0, 1'b0, 1'b0);
      cycle(8'h00, 1'b0, 1'b0, 1'b0);
      check("click_second_dropped", click_x, 5);
      cycle(8'h00, 1'b0, 1'b1, 1'b0);
      cycle(8'h00, 1'b0, 1'b0, 1'b0);
      check("click_accepted", click_valid, 0);

      frame(8'h07, 3);
      cycle(8'h2C, 1'b1, 1'b0, 1'b0);
      cycle(8'h2C, 1'b0, 1'b0, 1'b0);
      check("same_tick_click_x", click_x, 8);
      check("same_tick_no_move", CursorX, 8);
      cycle(8'h2C, 1'b0, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b0, 1'b0);
      check("reset_click", click_valid, 0);
      check("reset_x", CursorX, 320);
      check("reset_y", CursorY, 240);

      for (int seg = 0; seg < 120; seg++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    kc = 8'h00;
            2:       kc = 8'h04;
            3:       kc = 8'h07;
            4:       kc = 8'h1A;
            5:       kc = 8'h16;
            6, 7:    kc = (seg % 2) ? 8'h07 : 8'h1A;
            8:       kc = 8'h2C;
            default: kc = 8'($urandom);
         endcase
         len = $urandom_range(4, 60);
         for (int c = 0; c < len; c++)
            cycle(kc, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 299) == 0));
      end

      repeat (3) cycle(8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge Clk);
      #2;
      check("pos_queue_drained", pos_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
